// File: rtl/strobe_gen.sv
// Strobe generator: issues one-cycle enable strobes every max(period,1) cycles,
// either for a finite burst (ending with a done pulse) or continuously until stopped.
module strobe_gen #(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    PERIOD_WIDTH = 8,
    parameter int    BURST_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [BURST_WIDTH-1:0]  burst_len,
    output logic                    en,
    output logic                    busy,
    output logic                    done,
    output logic [BURST_WIDTH-1:0]  strobe_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] PER_ZERO = {PERIOD_WIDTH{1'b0}};
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0]  CNT_ZERO = {BURST_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0]  CNT_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state, w_state_nxt;
    logic [PERIOD_WIDTH-1:0] r_per, w_per_nxt;
    logic [PERIOD_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [BURST_WIDTH-1:0]  r_len, w_len_nxt;
    logic [BURST_WIDTH-1:0]  r_strobe_cnt, w_strobe_cnt_nxt;
    logic                    r_en, w_en_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_last;

    // Cycles to wait after a strobe before the next one; period 0 behaves like 1.
    function automatic logic [PERIOD_WIDTH-1:0] reload_of(input logic [PERIOD_WIDTH-1:0] p);
        if (p == PER_ZERO) begin
            reload_of = PER_ZERO;
        end else begin
            reload_of = p - PER_ONE;
        end
    endfunction

    // The cycle holding the final strobe of a finite burst.
    assign w_last = r_en && (r_len != CNT_ZERO) && (r_strobe_cnt == r_len);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_per_nxt        = r_per;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        w_strobe_cnt_nxt = r_strobe_cnt;
        w_en_nxt         = 1'b0;
        w_done_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_nxt      = RUN;
                    w_per_nxt        = period;
                    w_len_nxt        = burst_len;
                    w_cnt_nxt        = reload_of(period);
                    w_strobe_cnt_nxt = CNT_ONE;
                    w_en_nxt         = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = PER_ZERO;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == PER_ZERO) begin
                    w_en_nxt         = 1'b1;
                    w_strobe_cnt_nxt = r_strobe_cnt + CNT_ONE;
                    w_cnt_nxt        = reload_of(r_per);
                end else begin
                    w_cnt_nxt = r_cnt - PER_ONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_per        <= PER_ZERO;
            r_len        <= CNT_ZERO;
            r_cnt        <= PER_ZERO;
            r_strobe_cnt <= CNT_ZERO;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_per        <= w_per_nxt;
            r_len        <= w_len_nxt;
            r_cnt        <= w_cnt_nxt;
            r_strobe_cnt <= w_strobe_cnt_nxt;
            r_en         <= w_en_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    generate
        if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
            assign en         = r_en;
            assign busy       = r_busy;
            assign done       = r_done;
            assign strobe_cnt = r_strobe_cnt;
        end else begin : g_unsupported
            assign en         = 1'b0;
            assign busy       = 1'b0;
            assign done       = 1'b0;
            assign strobe_cnt = CNT_ZERO;
        end
    endgenerate

endmodule

// File: tb/tb_strobe_gen.sv
// Bench for strobe_gen: directed scenarios plus random traffic, checked every cycle
// against an arithmetic model of when strobes, busy, done and the count should appear.
module tb_strobe_gen;

    localparam int COUNT_FROM = 0;
    localparam int STEP       = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] period = 8'd0;
    logic [7:0] burst_len = 8'd0;
    logic       en, busy, done;
    logic [7:0] strobe_cnt;
    logic [7:0] ctr;

    int checks = 0;
    int errors = 0;

    // Model state: sequence accepted at edge number acc, with effective period,
    // burst length, and first cycle offset silenced by a stop (0 = no stop).
    int edges = 0;
    int acc = 0;
    int m_eff = 1;
    int m_n = 0;
    int stop_cs = 0;
    bit have_seq = 1'b0;

    always #5 clk = ~clk;

    strobe_gen #(
        .ARCHITECTURE("BEHAVIORAL"),
        .PERIOD_WIDTH(8),
        .BURST_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .period(period),
        .burst_len(burst_len),
        .en(en),
        .busy(busy),
        .done(done),
        .strobe_cnt(strobe_cnt)
    );

    // Downstream counter enabled by the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ctr <= 8'(COUNT_FROM);
        else if (en) ctr <= ctr + 8'(STEP);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs in cycle offset c (offset 1 = cycle right after the accepting edge).
    function automatic void model(input int c, output logic o_en, output logic o_busy,
                                  output logic o_done, output int o_cnt);
        int k, last, n_seen;
        o_en = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_cnt = 0;
        if (!have_seq) return;
        k    = (c - 1) / m_eff;
        last = (m_n > 0) ? 1 + (m_n - 1) * m_eff : 0;
        if (stop_cs != 0 && c >= stop_cs) begin
            n_seen = (stop_cs - 2) / m_eff + 1;
        end else begin
            n_seen = k + 1;
            o_en   = ((c - 1) % m_eff == 0) && (m_n == 0 || k < m_n);
            o_busy = (m_n == 0) || (c <= last);
            o_done = (m_n > 0) && (c == last + 1);
        end
        if (m_n > 0 && n_seen > m_n) n_seen = m_n;
        o_cnt = n_seen % 256;
    endfunction

    // One clock: drive inputs, take the edge, update the model, compare all outputs.
    task automatic step(input logic st, input logic sp, input logic [7:0] per, input logic [7:0] bl);
        logic e_en, e_busy, e_done;
        int   e_cnt, c;
        bit   idle, busy_now;
        idle = 1'b1;
        busy_now = 1'b0;
        c = edges - acc + 1;
        if (have_seq) begin
            model(c, e_en, e_busy, e_done, e_cnt);
            idle = !e_busy && !e_done;
            busy_now = e_busy;
        end
        start = st; stop = sp; period = per; burst_len = bl;
        @(posedge clk);
        edges++;
        if (st && !sp && idle) begin
            have_seq = 1'b1; acc = edges; m_eff = (per == 8'd0) ? 1 : int'(per);
            m_n = int'(bl); stop_cs = 0;
        end else if (sp && busy_now) begin
            stop_cs = c + 1;
        end
        #1;
        model(edges - acc + 1, e_en, e_busy, e_done, e_cnt);
        check("en", 32'(en), 32'(e_en));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("strobe_cnt", 32'(strobe_cnt), 32'(e_cnt));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_en", 32'(en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(strobe_cnt), 32'd0);
        have_seq = 1'b0;
        #2 rst = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // period 3, burst 4
        step(1'b1, 1'b0, 8'd3, 8'd4);
        idle_steps(10);
        check("b34_done", 32'(done), 32'd1);
        check("b34_busy", 32'(busy), 32'd0);
        check("b34_cnt", 32'(strobe_cnt), 32'd4);
        idle_steps(3);

        // restart attempt mid-burst with 1/1 must be ignored
        step(1'b1, 1'b0, 8'd3, 8'd4);
        idle_steps(3);
        step(1'b1, 1'b0, 8'd1, 8'd1);
        idle_steps(8);
        step(1'b1, 1'b0, 8'd1, 8'd1);
        idle_steps(3);

        // period 5, burst 10, stop at the edge that would make the 3rd strobe
        step(1'b1, 1'b0, 8'd5, 8'd10);
        idle_steps(9);
        step(1'b0, 1'b1, 8'd0, 8'd0);
        check("stop_cnt", 32'(strobe_cnt), 32'd2);
        check("stop_busy", 32'(busy), 32'd0);
        idle_steps(12);

        // continuous, every cycle, wraps past 255
        step(1'b1, 1'b0, 8'd0, 8'd0);
        idle_steps(299);
        check("cont_cnt300", 32'(strobe_cnt), 32'd44);
        step(1'b0, 1'b1, 8'd0, 8'd0);
        check("cont_stop_en", 32'(en), 32'd0);
        idle_steps(3);

        // start and stop together in idle: stop wins
        step(1'b1, 1'b1, 8'd3, 8'd4);
        check("startstop_busy", 32'(busy), 32'd0);
        idle_steps(2);

        // max period: no counter overflow
        step(1'b1, 1'b0, 8'd255, 8'd2);
        idle_steps(260);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
                 8'($urandom_range(0, 6)), 8'($urandom_range(0, 5)));
        end
        step(1'b0, 1'b1, 8'd0, 8'd0);
        idle_steps(3);

        // async reset mid-run, then period 2, burst 1
        step(1'b1, 1'b0, 8'd3, 8'd4);
        idle_steps(2);
        do_reset();
        step(1'b1, 1'b0, 8'd2, 8'd1);
        check("r_single_en", 32'(en), 32'd1);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        check("r_single_done", 32'(done), 32'd1);
        idle_steps(3);

        // strobe drives a downstream counter: period 4, burst 8
        do_reset();
        check("ctr_init", 32'(ctr), 32'd0);
        step(1'b1, 1'b0, 8'd4, 8'd8);
        idle_steps(39);
        check("ctr_final", 32'(ctr), 32'd8);
        idle_steps(5);
        check("ctr_hold", 32'(ctr), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
